// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: redirect arbitration, in-flight imem request
// tracking and squashing of responses that belong to an abandoned fetch path.
package core_pkg;
  parameter int XLEN = 32;
endpackage

module fetch_ctrl #(
  parameter int MAX_OUT = 4,
  parameter int XLEN    = core_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     dec_stall_req,
  input  logic                     be_redir_req,
  input  logic [XLEN-1:0]          be_redir_pc,
  input  logic                     dec_redir_req,
  input  logic [XLEN-1:0]          dec_redir_pc,
  input  logic                     imem_ren,
  input  logic                     mem_valid,
  input  logic [XLEN-1:0]          mem_rdata0,
  input  logic [XLEN-1:0]          mem_rdata1,
  input  logic [XLEN-1:0]          mem_pc0,
  input  logic [XLEN-1:0]          mem_pc1,
  output logic                     fetch_en,
  output logic                     stall,
  output logic                     redirect_en,
  output logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_valid,
  output logic [XLEN-1:0]          imem_rdata0,
  output logic [XLEN-1:0]          imem_rdata1,
  output logic [XLEN-1:0]          imem_pc0,
  output logic [XLEN-1:0]          imem_pc1,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     ovf_err
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, RUN, REDIR} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [MAX_OUT-1:0] live_q, live_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              redir_acc, full, empty, push_ok, pop_ok;

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    redir_acc     = (state_q != IDLE) & (be_redir_req | dec_redir_req);
    if (redir_acc) redirect_pc_d = be_redir_req ? be_redir_pc : dec_redir_pc;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (redir_acc) state_d = REDIR;
               else if (!enable) state_d = IDLE;
      REDIR:   state_d = redir_acc ? REDIR : RUN;
      default: state_d = IDLE;
    endcase
  end

  // A push while full is still legal when the same cycle pops the head.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    pop_ok   = mem_valid & ~empty;
    push_ok  = imem_ren & (~full | mem_valid);
    live_d   = live_q;
    if (redir_acc) live_d = '0;
    if (push_ok) live_d[wr_ptr_q] = ~redir_acc;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d    = ovf_q | (imem_ren & full & ~mem_valid) | (mem_valid & empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      live_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      live_q        <= live_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
    end
  end

  assign fetch_en    = (state_q != IDLE) & enable;
  assign stall       = dec_stall_req | (full & ~mem_valid);
  assign redirect_en = (state_q == REDIR);
  assign redirect_pc = redirect_pc_q;
  assign imem_valid  = mem_valid & ~empty & live_q[rd_ptr_q] & ~redir_acc;
  assign imem_rdata0 = mem_rdata0;
  assign imem_rdata1 = mem_rdata1;
  assign imem_pc0    = mem_pc0;
  assign imem_pc1    = mem_pc1;
  assign outstanding = count_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a latency-programmable memory model feeds
// responses, and a queue of expected live flags is popped per response.
module tb_fetch_ctrl;

  localparam int XL  = 32;
  localparam int MO  = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset, enable, dec_stall_req;
  logic          be_redir_req, dec_redir_req, imem_ren, mem_valid;
  logic [XL-1:0] be_redir_pc, dec_redir_pc;
  logic [XL-1:0] mem_rdata0, mem_rdata1, mem_pc0, mem_pc1;
  logic          fetch_en, stall, redirect_en, imem_valid, ovf_err;
  logic [XL-1:0] redirect_pc, imem_rdata0, imem_rdata1, imem_pc0, imem_pc1;
  logic [$clog2(MO):0] outstanding;

  fetch_ctrl #(.MAX_OUT(MO), .XLEN(XL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dec_stall_req(dec_stall_req),
    .be_redir_req(be_redir_req), .be_redir_pc(be_redir_pc),
    .dec_redir_req(dec_redir_req), .dec_redir_pc(dec_redir_pc),
    .imem_ren(imem_ren), .mem_valid(mem_valid),
    .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1),
    .mem_pc0(mem_pc0), .mem_pc1(mem_pc1),
    .fetch_en(fetch_en), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_valid(imem_valid),
    .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1),
    .imem_pc0(imem_pc0), .imem_pc1(imem_pc1),
    .outstanding(outstanding), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XL-1:0] pc;
    int            due;
  } req_t;

  req_t          pipe[$];
  bit            live_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  int            st    = 0;
  logic [XL-1:0] exp_rpc = '0;
  logic [XL-1:0] fpc = 32'h100;
  bit            exp_ovf = 1'b0;
  bit            hold = 1'b0;

  task automatic check(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input bit ren, input bit be, input logic [XL-1:0] bpc,
                      input bit de, input logic [XL-1:0] dpc, input bit dstall);
    bit   racc, mv, lv;
    int   sz;
    req_t r;
    r    = '0;
    sz   = live_q.size();
    racc = (be | de) && (st != 0);
    mv   = 1'b0;
    if (!hold && pipe.size() > 0 && pipe[0].due <= cyc) begin
      r  = pipe.pop_front();
      mv = 1'b1;
    end
    imem_ren      = ren;
    be_redir_req  = be;
    be_redir_pc   = bpc;
    dec_redir_req = de;
    dec_redir_pc  = dpc;
    dec_stall_req = dstall;
    mem_valid     = mv;
    mem_pc0       = r.pc;
    mem_pc1       = r.pc + 4;
    mem_rdata0    = ~r.pc;
    mem_rdata1    = r.pc ^ 32'h5A5A_0000;
    @(negedge clk);
    check("outstanding", outstanding, sz);
    check("stall", stall, dstall | (sz == MO && !mv));
    check("fetch_en", fetch_en, (st != 0) && enable);
    check("redirect_en", redirect_en, st == 2);
    check("redirect_pc", redirect_pc, exp_rpc);
    check("ovf_err", ovf_err, exp_ovf);
    if (mv) begin
      lv = (live_q.size() > 0) ? live_q[0] : 1'b0;
      check("imem_valid", imem_valid, lv && !racc);
      check("imem_pc0", imem_pc0, r.pc);
      check("imem_rdata1", imem_rdata1, r.pc ^ 32'h5A5A_0000);
      if (live_q.size() > 0) void'(live_q.pop_front());
      else exp_ovf = 1'b1;
    end else begin
      check("imem_valid_quiet", imem_valid, 1'b0);
    end
    if (racc) foreach (live_q[i]) live_q[i] = 1'b0;
    if (ren) begin
      if (sz < MO || mv) begin
        live_q.push_back(!racc);
        pipe.push_back('{pc: fpc, due: cyc + LAT});
        fpc += 8;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (racc) begin
      exp_rpc = be ? bpc : dpc;
      fpc     = exp_rpc;
    end
    case (st)
      0:       st = enable ? 1 : 0;
      1:       st = racc ? 2 : (enable ? 1 : 0);
      default: st = racc ? 2 : 1;
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input bit ren);
    for (int i = 0; i < n; i++) tick(ren, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; dec_stall_req = 1'b0;
    be_redir_req = 1'b0; dec_redir_req = 1'b0; imem_ren = 1'b0; mem_valid = 1'b0;
    be_redir_pc = '0; dec_redir_pc = '0;
    mem_rdata0 = '0; mem_rdata1 = '0; mem_pc0 = '0; mem_pc1 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Redirect while IDLE must be ignored.
    tick(1'b0, 1'b1, 32'h99, 1'b0, '0, 1'b0);
    run(1, 1'b0);

    enable = 1'b1;
    run(1, 1'b0);
    run(8, 1'b1);

    tick(1'b1, 1'b1, 32'h40, 1'b0, '0, 1'b0);
    run(6, 1'b1);

    tick(1'b1, 1'b1, 32'h80, 1'b1, 32'h14, 1'b0);
    run(4, 1'b1);

    tick(1'b1, 1'b0, '0, 1'b1, 32'h14, 1'b0);
    tick(1'b1, 1'b1, 32'h80, 1'b0, '0, 1'b0);
    run(5, 1'b1);
    run(3, 1'b0);

    hold = 1'b1;
    run(4, 1'b1);
    run(1, 1'b0);
    run(1, 1'b1);
    run(1, 1'b0);
    hold = 1'b0;
    run(1, 1'b1);
    run(6, 1'b0);

    tick(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

    run(2, 1'b1);
    enable = 1'b0;
    run(4, 1'b0);

    enable = 1'b1;
    run(1, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b1, 32'h200, 1'b0);
    hold = 1'b1;
    run(3, 1'b1);

    imem_ren = 1'b0; be_redir_req = 1'b0; dec_redir_req = 1'b0;
    mem_valid = 1'b0; dec_stall_req = 1'b0; enable = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    pipe.delete();
    live_q.delete();
    st = 0; exp_rpc = '0; exp_ovf = 1'b0; hold = 1'b0;
    run(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
